mblock_arb: RTL and testbench

Round-robin scheduler that time-shares one DSP-based multiple-constant-multiplier block (X·5748 → 21 b, X·87 → 15 b, 1-clk registered latency) between NREQ requesters. It sits between requester ports and the shared block:
- drives the block's X input;
- tracks each issued operand's owner through the block latency;
- buffers results in a credit-controlled FIFO so response back-pressure never drops a product.

---
 rtl/mblock_arb.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_mblock_arb.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mblock_arb.sv
// ---------------------------------------------------------------------------
// mblock_arb
//   Round-robin scheduler sharing one multiple-constant-multiplier block
//   (X*5748 and X*87, LAT clocks of latency) between NREQ requesters.
//   A tag pipeline follows each issued operand through the block, and a
//   credit-controlled result FIFO absorbs response back-pressure so that no
//   product is ever dropped.
//
//   Optional feature macro: MBLOCK_ARB_STATS_EN (adds issue/stall counters).
//
// Ports
//   clk         clock shared with the multiplier block
//   rst         synchronous active-high reset
//   req_valid   per-requester operand valid            [NREQ]
//   req_x       packed signed operands, i at [i*XW +: XW]
//   req_ready   one-hot-or-zero accept                 [NREQ]
//   mb_x        operand to the shared block            [XW]
//   mb_y0       X*5748 from the shared block           [Y0W]
//   mb_y1       X*87 from the shared block             [Y1W]
//   rsp_valid   head result available
//   rsp_ready   consumer accepts head result
//   rsp_id      owner of the head result               [$clog2(NREQ)]
//   rsp_y0      head X*5748                            [Y0W]
//   rsp_y1      head X*87                              [Y1W]
//   stat_issue  (MBLOCK_ARB_STATS_EN) wrapping issue count      [32]
//   stat_stall  (MBLOCK_ARB_STATS_EN) wrapping stall-cycle count [32]
// ---------------------------------------------------------------------------
module mblock_arb #(
  parameter int NREQ   = 4,
  parameter int XW     = 8,
  parameter int Y0W    = 21,
  parameter int Y1W    = 15,
  parameter int LAT    = 1,
  parameter int FDEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*XW-1:0]        req_x,
  output logic [NREQ-1:0]           req_ready,
  output logic [XW-1:0]             mb_x,
  input  logic [Y0W-1:0]            mb_y0,
  input  logic [Y1W-1:0]            mb_y1,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [Y0W-1:0]            rsp_y0,
  output logic [Y1W-1:0]            rsp_y1
`ifdef MBLOCK_ARB_STATS_EN
  ,
  output logic [31:0]               stat_issue,
  output logic [31:0]               stat_stall
`endif
);

  localparam int IW = $clog2(NREQ);
  localparam int PW = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
  localparam int CW = $clog2(FDEPTH + 1);

  // FIFO pointer advance with wrap at FDEPTH (depth need not be a power of 2).
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    logic [PW-1:0] r;
    if (p == PW'(FDEPTH - 1)) begin
      r = {PW{1'b0}};
    end else begin
      r = p + PW'(1);
    end
    return r;
  endfunction

  // Arbitration state and decisions
  logic [IW-1:0]   last_r;
  logic            gnt_vld_s;
  logic [IW-1:0]   gnt_idx_s;
  logic            credit_ok_s;
  logic            issue_s;
  logic [CW-1:0]   credit_r;

  // Tag pipeline: one {valid, id} pair per block latency stage
  logic [LAT-1:0]  tag_vld_r;
  logic [IW-1:0]   tag_id_r [LAT];

  // Result FIFO
  logic [IW-1:0]   fifo_id_r [FDEPTH];
  logic [Y0W-1:0]  fifo_y0_r [FDEPTH];
  logic [Y1W-1:0]  fifo_y1_r [FDEPTH];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic            fifo_wr_s;
  logic            pop_s;

  // Round-robin search starting one past the last grant, wrapping modulo NREQ.
  always_comb begin
    logic [IW:0]   sum;
    logic [IW-1:0] cand;
    gnt_vld_s = 1'b0;
    gnt_idx_s = {IW{1'b0}};
    sum       = {(IW+1){1'b0}};
    cand      = {IW{1'b0}};
    for (int k = 1; k <= NREQ; k++) begin
      sum = {1'b0, last_r} + (IW+1)'(k);
      if (sum >= (IW+1)'(NREQ)) begin
        sum = sum - (IW+1)'(NREQ);
      end else begin
        sum = sum;
      end
      cand = sum[IW-1:0];
      if (!gnt_vld_s && req_valid[cand]) begin
        gnt_vld_s = 1'b1;
        gnt_idx_s = cand;
      end else begin
        gnt_vld_s = gnt_vld_s;
      end
    end
  end

  // Accept/issue decision and operand mux toward the shared block.
  always_comb begin
    credit_ok_s = (credit_r < CW'(FDEPTH));
    // Reset gates the accept directly so nothing is issued while rst is high.
    issue_s     = gnt_vld_s & credit_ok_s & ~rst;
    if (issue_s) begin
      req_ready = NREQ'(1) << gnt_idx_s;
      mb_x      = req_x[gnt_idx_s*XW +: XW];
    end else begin
      req_ready = {NREQ{1'b0}};
      mb_x      = {XW{1'b0}};
    end
  end

  // Round-robin pointer: moves to the granted index only on an issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_r <= IW'(NREQ - 1);
    end else if (issue_s) begin
      last_r <= gnt_idx_s;
    end else begin
      last_r <= last_r;
    end
  end

  // Tag shift register tracking operand ownership through the block latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_r <= {LAT{1'b0}};
      for (int i = 0; i < LAT; i++) begin
        tag_id_r[i] <= {IW{1'b0}};
      end
    end else begin
      tag_vld_r[0] <= issue_s;
      tag_id_r[0]  <= gnt_idx_s;
      for (int i = 1; i < LAT; i++) begin
        tag_vld_r[i] <= tag_vld_r[i-1];
        tag_id_r[i]  <= tag_id_r[i-1];
      end
    end
  end

  // FIFO handshake strobes; the write is gated by rst so products of
  // operands issued before a reset are never stored.
  always_comb begin
    fifo_wr_s = tag_vld_r[LAT-1] & ~rst;
    pop_s     = rsp_valid & rsp_ready;
  end

  // FIFO storage write; no reset needed because unread entries are masked.
  always_ff @(posedge clk) begin
    if (fifo_wr_s) begin
      fifo_id_r[wr_ptr_r] <= tag_id_r[LAT-1];
      fifo_y0_r[wr_ptr_r] <= mb_y0;
      fifo_y1_r[wr_ptr_r] <= mb_y1;
    end
  end

  // FIFO pointers and occupancy; write and pop may coincide even when full.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (fifo_wr_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      count_r <= count_r + CW'(fifo_wr_s) - CW'(pop_s);
    end
  end

  // Credit = in-flight tags + FIFO occupancy; bounds issues to free FIFO slots.
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_r <= {CW{1'b0}};
    end else begin
      credit_r <= credit_r + CW'(issue_s) - CW'(pop_s);
    end
  end

  // Head-of-FIFO presentation; fields read as zero while empty.
  always_comb begin
    rsp_valid = (count_r != {CW{1'b0}});
    if (rsp_valid) begin
      rsp_id = fifo_id_r[rd_ptr_r];
      rsp_y0 = fifo_y0_r[rd_ptr_r];
      rsp_y1 = fifo_y1_r[rd_ptr_r];
    end else begin
      rsp_id = {IW{1'b0}};
      rsp_y0 = {Y0W{1'b0}};
      rsp_y1 = {Y1W{1'b0}};
    end
  end

`ifdef MBLOCK_ARB_STATS_EN
  // Wrapping issue and stall counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issue <= 32'd0;
      stat_stall <= 32'd0;
    end else begin
      if (issue_s) begin
        stat_issue <= stat_issue + 32'd1;
      end
      if ((|req_valid) && !issue_s) begin
        stat_stall <= stat_stall + 32'd1;
      end
    end
  end
`endif

  mblock_arb_chk #(
    .FDEPTH (FDEPTH),
    .CW     (CW)
  ) u_chk (
    .clk        (clk),
    .rst        (rst),
    .fifo_wr    (fifo_wr_s),
    .fifo_pop   (pop_s),
    .fifo_count (count_r),
    .credit     (credit_r)
  );

endmodule

// ---------------------------------------------------------------------------
// mblock_arb_chk
//   Invariant checker for mblock_arb: FIFO never overflows, credit stays
//   within FDEPTH and always covers the FIFO occupancy.
// Ports
//   clk, rst    clock and synchronous reset of the checked block
//   fifo_wr     FIFO write strobe
//   fifo_pop    FIFO pop strobe
//   fifo_count  FIFO occupancy [CW]
//   credit      outstanding credit [CW]
// ---------------------------------------------------------------------------
module mblock_arb_chk #(
  parameter int FDEPTH = 4,
  parameter int CW     = 3
) (
  input logic          clk,
  input logic          rst,
  input logic          fifo_wr,
  input logic          fifo_pop,
  input logic [CW-1:0] fifo_count,
  input logic [CW-1:0] credit
);

  // A write into a full FIFO is legal only when the head leaves in the same cycle.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(fifo_wr && !fifo_pop && (fifo_count == CW'(FDEPTH))));

  a_credit_bound: assert property (@(posedge clk) disable iff (rst)
    credit <= CW'(FDEPTH));

  a_credit_covers: assert property (@(posedge clk) disable iff (rst)
    credit >= fifo_count);

endmodule

// File: tb/tb_mblock_arb.sv
module tb_mblock_arb;

  localparam int NREQ   = 4;
  localparam int XW     = 8;
  localparam int Y0W    = 21;
  localparam int Y1W    = 15;
  localparam int LAT    = 1;
  localparam int FDEPTH = 4;
  localparam int IW     = $clog2(NREQ);

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*XW-1:0]   req_x;
  logic [NREQ-1:0]      req_ready;
  logic [XW-1:0]        mb_x;
  logic [Y0W-1:0]       mb_y0;
  logic [Y1W-1:0]       mb_y1;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IW-1:0]        rsp_id;
  logic [Y0W-1:0]       rsp_y0;
  logic [Y1W-1:0]       rsp_y1;
`ifdef MBLOCK_ARB_STATS_EN
  logic [31:0]          stat_issue;
  logic [31:0]          stat_stall;
`endif

  mblock_arb #(
    .NREQ(NREQ), .XW(XW), .Y0W(Y0W), .Y1W(Y1W), .LAT(LAT), .FDEPTH(FDEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_x     (req_x),
    .req_ready (req_ready),
    .mb_x      (mb_x),
    .mb_y0     (mb_y0),
    .mb_y1     (mb_y1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_y0    (rsp_y0),
    .rsp_y1    (rsp_y1)
`ifdef MBLOCK_ARB_STATS_EN
    ,
    .stat_issue(stat_issue),
    .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural shared multiplier block, one registered stage.
  always @(posedge clk) begin
    mb_y0 <= Y0W'($signed(mb_x) * 5748);
    mb_y1 <= Y1W'($signed(mb_x) * 87);
  end

  typedef struct {
    int id;
    int y0;
    int y1;
    int due;
  } rsp_t;

  int            checks = 0;
  int            errors = 0;
  int            cyc    = 0;
  int            mlast  = NREQ - 1;
  int            dut_iss = 0;
  int            st_issue = 0;
  int            st_stall = 0;
  rsp_t          q[$];
  logic [XW-1:0] xv [NREQ];

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_x();
    for (int i = 0; i < NREQ; i++) req_x[i*XW +: XW] = xv[i];
  endtask

  // One clock: check outputs against the reference model mid-cycle, then
  // advance the model across the rising edge.
  task automatic tick();
    int   g;
    int   idx;
    int   ex;
    bit   found;
    bit   iss;
    bit   head;
    bit   pp;
    logic [NREQ-1:0] er;
    rsp_t e;
    @(negedge clk);
    found = 1'b0;
    g = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (mlast + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        g = idx;
      end
    end
    iss = !rst && found && (q.size() < FDEPTH);
    er = '0;
    if (iss) er[g] = 1'b1;
    chk("req_ready", req_ready, er);
    ex = iss ? int'($signed(xv[g])) : 0;
    chk("mb_x", $signed(mb_x), ex);
    if ((req_valid & req_ready) != '0) dut_iss++;
    head = (q.size() > 0) && (q[0].due <= cyc);
    chk("rsp_valid", rsp_valid, head);
    if (head) begin
      chk("rsp_id", rsp_id, q[0].id);
      chk("rsp_y0", $signed(rsp_y0), q[0].y0);
      chk("rsp_y1", $signed(rsp_y1), q[0].y1);
    end
    pp = head && rsp_ready;
    @(posedge clk);
    cyc++;
    if (rst) begin
      mlast = NREQ - 1;
      q.delete();
      st_issue = 0;
      st_stall = 0;
    end else begin
      if (pp) void'(q.pop_front());
      if (iss) begin
        e.id  = g;
        e.y0  = int'($signed(xv[g])) * 5748;
        e.y1  = int'($signed(xv[g])) * 87;
        e.due = cyc + LAT;
        q.push_back(e);
        mlast = g;
        st_issue++;
      end
      if ((|req_valid) && !iss) st_stall++;
    end
    #1;
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Lone request with known operand; response must appear two cycles later.
  task automatic one_shot(input int r, input int x, input int e0, input int e1);
    logic [NREQ-1:0] v;
    v = '0;
    v[r] = 1'b1;
    rsp_ready = 1'b1;
    xv[r] = XW'(x);
    set_x();
    req_valid = v;
    #1;
    chk("one_ready", req_ready, v);
    tick();
    req_valid = '0;
    tick();
    chk("one_valid", rsp_valid, 1);
    chk("one_id", rsp_id, r);
    chk("one_y0", $signed(rsp_y0), e0);
    chk("one_y1", $signed(rsp_y1), e1);
    tick();
    tick();
  endtask

  initial begin
    req_valid = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) xv[i] = '0;
    set_x();
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_y0", rsp_y0, 0);
    chk("rst_rsp_y1", rsp_y1, 0);
    chk("rst_mb_x", mb_x, 0);
    req_valid = '1;
    #1;
    chk("rst_req_ready", req_ready, 0);
    tick();
    req_valid = '0;
    rst = 1'b0;

    // Single request from requester 2, X = 3
    one_shot(2, 3, 17244, 261);

    // Sign and extremes
    one_shot(0, -1, -5748, -87);
    one_shot(1, -128, -735744, -11136);
    one_shot(3, 127, 729996, 11049);

    // Fairness: all valid, X = i+1, one grant per clock in order 0,1,2,3,...
    rst_pulse();
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) xv[i] = XW'(i + 1);
    set_x();
    req_valid = '1;
    for (int k = 0; k < 16; k++) begin
      #1;
      chk("fair_grant", req_ready, NREQ'(1) << (k % NREQ));
      tick();
    end
    req_valid = '0;
    repeat (4) tick();

    // Back-pressure: exactly FDEPTH issues, then resume one cycle after first pop
    rst_pulse();
    rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) xv[i] = XW'($urandom);
    set_x();
    req_valid = '1;
    dut_iss = 0;
    repeat (8) tick();
    chk("bp_issues", dut_iss, FDEPTH);
    chk("bp_ready_low", req_ready, 0);
    rsp_ready = 1'b1;
    #1;
    chk("bp_head", rsp_valid, 1);
    chk("bp_no_issue_pop_cycle", req_ready, 0);
    tick();
    chk("bp_resume", |req_ready, 1);
    repeat (6) tick();
    req_valid = '0;
    repeat (6) tick();

    // Randomized traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      req_valid = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) xv[i] = XW'($urandom);
      set_x();
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 49) == 0);
      tick();
    end
    rst = 1'b0;
`ifdef MBLOCK_ARB_STATS_EN
    chk("stat_issue_model", stat_issue, st_issue);
    chk("stat_stall_model", stat_stall, st_stall);
`endif
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (8) tick();

    // Reset one cycle after an issue discards the product
    rst_pulse();
    rsp_ready = 1'b1;
    xv[1] = XW'($urandom);
    set_x();
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("rmf_no_rsp", rsp_valid, 0);
      tick();
    end
    req_valid = '1;
    #1;
    chk("rmf_grant0", req_ready, 1);
    tick();
    req_valid = '0;
    repeat (4) tick();

`ifdef MBLOCK_ARB_STATS_EN
    // 10 issues plus 3 stalled cycles
    rst_pulse();
    chk("stat_issue_rst", stat_issue, 0);
    chk("stat_stall_rst", stat_stall, 0);
    rsp_ready = 1'b0;
    req_valid = '1;
    repeat (7) tick();
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (6) tick();
    req_valid = '1;
    repeat (6) tick();
    req_valid = '0;
    repeat (4) tick();
    chk("stat_issue_10", stat_issue, 10);
    chk("stat_stall_3", stat_stall, 3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
